// File: rtl/morse_key_sequencer_if.sv
// Port bundle for morse_key_sequencer: raw key/confirm/clear inputs plus the letter history,
// the in-progress pattern and status flags.
interface morse_key_sequencer_if;
  logic        key;
  logic        confirm;
  logic        clear;
  logic [15:0] letter0;
  logic [15:0] letter1;
  logic [15:0] letter2;
  logic [15:0] letter3;
  logic [15:0] letter4;
  logic [15:0] cur_code;
  logic [2:0]  sym_count;
  logic [2:0]  letter_count;
  logic        commit;
  logic        overflow;
  logic        key_led;

  modport master (
    output key, confirm, clear,
    input  letter0, letter1, letter2, letter3, letter4,
    input  cur_code, sym_count, letter_count, commit, overflow, key_led
  );

  modport slave (
    input  key, confirm, clear,
    output letter0, letter1, letter2, letter3, letter4,
    output cur_code, sym_count, letter_count, commit, overflow, key_led
  );
endinterface

// File: rtl/morse_key_sequencer.sv
// Single-key Morse entry: times presses/gaps, builds a dot/dash pattern and shifts committed
// letters into a 5-deep history. Define MORSE_WORD_SPACE_EN to push a blank after a long idle.
module morse_key_sequencer #(
  parameter int unsigned UNIT_CYC   = 250000,
  parameter int unsigned GLITCH_CYC = 5000,
  parameter int unsigned CNT_W      = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  morse_key_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StPress, StGap, StCommit} state_e;

  localparam logic [CNT_W-1:0] GlitchCyc = CNT_W'(GLITCH_CYC);
  localparam logic [CNT_W-1:0] DashCyc   = CNT_W'(2 * UNIT_CYC);
  localparam logic [CNT_W-1:0] GapCyc    = CNT_W'(3 * UNIT_CYC);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  // Input synchronizers
  logic key_s1_q, key_s2_q;
  logic conf_s1_q, conf_s2_q, conf_prev_q;
  logic conf_edge;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [15:0]      cur_q, cur_d;
  logic [2:0]       sym_q, sym_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      hist_q [5];
  logic [2:0]       lcnt_q;
  logic             push;

`ifdef MORSE_WORD_SPACE_EN
  localparam logic [CNT_W-1:0] WordCyc = CNT_W'(7 * UNIT_CYC);
  logic armed_q;
`endif

  assign conf_edge = conf_s2_q & ~conf_prev_q;
  assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_s1_q    <= 1'b0;
      key_s2_q    <= 1'b0;
      conf_s1_q   <= 1'b0;
      conf_s2_q   <= 1'b0;
      conf_prev_q <= 1'b0;
    end else if (bus.clear) begin
      key_s1_q    <= 1'b0;
      key_s2_q    <= 1'b0;
      conf_s1_q   <= 1'b0;
      conf_s2_q   <= 1'b0;
      conf_prev_q <= 1'b0;
    end else begin
      key_s1_q    <= bus.key;
      key_s2_q    <= key_s1_q;
      conf_s1_q   <= bus.confirm;
      conf_s2_q   <= conf_s1_q;
      conf_prev_q <= conf_s2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    sym_d   = sym_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (key_s2_q) begin
          state_d = StPress;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
`ifdef MORSE_WORD_SPACE_EN
          if (armed_q && (cnt_q >= WordCyc)) begin
            state_d = StCommit;
            push    = 1'b1;
          end
`endif
        end
      end
      StPress: begin
        if (key_s2_q) begin
          cnt_d = cnt_inc;
        end else begin
          cnt_d   = '0;
          state_d = StGap;
          if (cnt_q < GlitchCyc) begin
            if (sym_q == 3'd0) state_d = StIdle;
          end else if (sym_q < 3'd4) begin
            cur_d = (cnt_q < DashCyc) ? {cur_q[13:0], 2'b10} : {cur_q[11:0], 4'b1110};
            sym_d = sym_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      StGap: begin
        // Confirm outranks a simultaneous key-down
        if (conf_edge || (cnt_q >= GapCyc)) begin
          state_d = StCommit;
          push    = 1'b1;
        end else if (key_s2_q) begin
          state_d = StPress;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StCommit: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
    if (push) begin
      cur_d = '0;
      sym_d = '0;
      ovf_d = 1'b0;
    end
  end

  // History shifts on the edge that enters COMMIT, so it is valid while commit is high
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cur_q   <= '0;
      sym_q   <= '0;
      ovf_q   <= 1'b0;
      lcnt_q  <= '0;
      for (int i = 0; i < 5; i++) hist_q[i] <= '0;
    end else if (bus.clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cur_q   <= '0;
      sym_q   <= '0;
      ovf_q   <= 1'b0;
      lcnt_q  <= '0;
      for (int i = 0; i < 5; i++) hist_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      sym_q   <= sym_d;
      ovf_q   <= ovf_d;
      if (push) begin
        for (int i = 4; i > 0; i--) hist_q[i] <= hist_q[i-1];
        hist_q[0] <= cur_q;
        lcnt_q    <= (lcnt_q == 3'd5) ? 3'd5 : lcnt_q + 3'd1;
      end
    end
  end

`ifdef MORSE_WORD_SPACE_EN
  // Blank commits carry sym_count 0 and therefore disarm until the next real letter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed_q <= 1'b0;
    end else if (bus.clear) begin
      armed_q <= 1'b0;
    end else if (push) begin
      armed_q <= (sym_q != 3'd0);
    end
  end
`endif

  assign bus.letter0      = hist_q[0];
  assign bus.letter1      = hist_q[1];
  assign bus.letter2      = hist_q[2];
  assign bus.letter3      = hist_q[3];
  assign bus.letter4      = hist_q[4];
  assign bus.cur_code     = cur_q;
  assign bus.sym_count    = sym_q;
  assign bus.letter_count = lcnt_q;
  assign bus.commit       = (state_q == StCommit);
  assign bus.overflow     = ovf_q;
  assign bus.key_led      = key_s2_q;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Bench for morse_key_sequencer with UNIT_CYC=10, GLITCH_CYC=3: table of single-symbol letters,
// hand-written multi-symbol/overflow/reset sequences, commit scoreboard.
module tb_morse_key_sequencer;
  localparam int unsigned Unit   = 10;
  localparam int unsigned Glitch = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  morse_key_sequencer_if bus ();

  morse_key_sequencer #(
    .UNIT_CYC  (Unit),
    .GLITCH_CYC(Glitch),
    .CNT_W     (8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          press;
    int          rel;
    bit          commits;
    logic [15:0] mid_code;
    logic [2:0]  mid_sym;
    logic [15:0] exp_l0;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t        vecs [7];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_q [$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input int p, input int r);
    bus.key = 1'b1;
    tick(p);
    bus.key = 1'b0;
    tick(r);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick(2);
    bus.clear = 1'b0;
    tick(1);
  endtask

  // Scoreboard: each commit pulse must match the oldest outstanding expected letter
  always @(negedge clock) begin
    if (reset && bus.commit) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_commit: letter0 %h, no commit expected", bus.letter0);
      end else begin
        chk("commit_letter0", bus.letter0, exp_q.pop_front());
      end
    end
  end

  initial begin
    vecs[0] = '{5,  40, 1'b1, 16'h0002, 3'd1, 16'h0002, 3'd1};
    vecs[1] = '{2,  40, 1'b0, 16'h0000, 3'd0, 16'h0002, 3'd1};
    vecs[2] = '{25, 40, 1'b1, 16'h000E, 3'd1, 16'h000E, 3'd2};
    vecs[3] = '{19, 40, 1'b1, 16'h0002, 3'd1, 16'h0002, 3'd3};
    vecs[4] = '{22, 40, 1'b1, 16'h000E, 3'd1, 16'h000E, 3'd4};
    vecs[5] = '{5,  40, 1'b1, 16'h0002, 3'd1, 16'h0002, 3'd5};
    vecs[6] = '{5,  40, 1'b1, 16'h0002, 3'd1, 16'h0002, 3'd5};

    bus.key     = 1'b0;
    bus.confirm = 1'b0;
    bus.clear   = 1'b0;
    tick(3);
    chk("rst_letter0", bus.letter0, 16'h0000);
    chk("rst_cur_code", bus.cur_code, 16'h0000);
    chk("rst_letter_count", 16'(bus.letter_count), 16'h0000);
    chk("rst_commit", 16'(bus.commit), 16'h0000);
    reset = 1'b1;
    tick(2);

    foreach (vecs[i]) begin
      if (vecs[i].commits) exp_q.push_back(vecs[i].exp_l0);
      press(vecs[i].press, 5);
      chk($sformatf("v%0d_cur_code", i), bus.cur_code, vecs[i].mid_code);
      chk($sformatf("v%0d_sym_count", i), 16'(bus.sym_count), 16'(vecs[i].mid_sym));
      tick(vecs[i].rel - 5);
      chk($sformatf("v%0d_letter0", i), bus.letter0, vecs[i].exp_l0);
      chk($sformatf("v%0d_letter_count", i), 16'(bus.letter_count), 16'(vecs[i].exp_cnt));
    end

    // Clear wipes history and count
    do_clear();
    chk("clr_letter0", bus.letter0, 16'h0000);
    chk("clr_letter4", bus.letter4, 16'h0000);
    chk("clr_letter_count", 16'(bus.letter_count), 16'h0000);

    // Six single-dot letters fill history; count saturates at 5
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(16'h0002);
      press(5, 40);
    end
    chk("six_letter_count", 16'(bus.letter_count), 16'h0005);
    chk("six_letter0", bus.letter0, 16'h0002);
    chk("six_letter1", bus.letter1, 16'h0002);
    chk("six_letter2", bus.letter2, 16'h0002);
    chk("six_letter3", bus.letter3, 16'h0002);
    chk("six_letter4", bus.letter4, 16'h0002);

    // Dash dot dash, committed early by confirm
    do_clear();
    exp_q.push_back(16'h03AE);
    press(25, 5);
    press(5, 5);
    press(25, 5);
    chk("kdk_cur_code", bus.cur_code, 16'h03AE);
    bus.confirm = 1'b1;
    tick(3);
    bus.confirm = 1'b0;
    tick(8);
    chk("confirm_pending", 16'(exp_q.size()), 16'h0000);
    chk("confirm_letter_count", 16'(bus.letter_count), 16'h0001);
    chk("confirm_cur_code", bus.cur_code, 16'h0000);
    tick(40);

    // Fifth symbol overflows; cleared by commit
    do_clear();
    for (int i = 0; i < 5; i++) press(25, 5);
    chk("ovf_cur_code", bus.cur_code, 16'hEEEE);
    chk("ovf_sym_count", 16'(bus.sym_count), 16'h0004);
    chk("ovf_flag", 16'(bus.overflow), 16'h0001);
    exp_q.push_back(16'hEEEE);
    tick(40);
    chk("ovf_letter0", bus.letter0, 16'hEEEE);
    chk("ovf_flag_after", 16'(bus.overflow), 16'h0000);
    chk("ovf_sym_after", 16'(bus.sym_count), 16'h0000);

    // Reset mid-press aborts the letter at once
    bus.key = 1'b1;
    tick(8);
    chk("key_led_high", 16'(bus.key_led), 16'h0001);
    reset = 1'b0;
    #1;
    chk("midrst_letter0", bus.letter0, 16'h0000);
    chk("midrst_letter_count", 16'(bus.letter_count), 16'h0000);
    chk("midrst_key_led", 16'(bus.key_led), 16'h0000);
    tick(7);
    bus.key = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(50);
    chk("postrst_letter_count", 16'(bus.letter_count), 16'h0000);
    chk("postrst_cur_code", bus.cur_code, 16'h0000);

    // Long idle after a letter: blank word space only when the feature is built in
    exp_q.push_back(16'h0002);
`ifdef MORSE_WORD_SPACE_EN
    exp_q.push_back(16'h0000);
    press(5, 130);
    chk("ws_letter0", bus.letter0, 16'h0000);
    chk("ws_letter1", bus.letter1, 16'h0002);
`else
    press(5, 130);
    chk("ws_letter0", bus.letter0, 16'h0002);
    chk("ws_letter1", bus.letter1, 16'h0000);
`endif
    chk("ws_letter2", bus.letter2, 16'h0000);
    chk("final_pending", 16'(exp_q.size()), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
